// File: rtl/mole_hit_encoder_if.sv
// Keypad-side bundle for mole_hit_encoder: scan drive/sense plus debounced hole code.
// MOLE_HIT_MASK_EN adds the active-mole mask input and the key_hit output.
interface mole_hit_encoder_if;
    logic [3:0] keypad_row;
    logic [3:0] keypad_col;
    logic [4:0] key_position;
    logic       key_valid;
    logic       key_held;
`ifdef MOLE_HIT_MASK_EN
    logic [15:0] mole16bit;
    logic        key_hit;

    modport slave (
        input  keypad_row,
        input  mole16bit,
        output keypad_col,
        output key_position,
        output key_valid,
        output key_held,
        output key_hit
    );

    modport master (
        output keypad_row,
        output mole16bit,
        input  keypad_col,
        input  key_position,
        input  key_valid,
        input  key_held,
        input  key_hit
    );
`else
    modport slave (
        input  keypad_row,
        output keypad_col,
        output key_position,
        output key_valid,
        output key_held
    );

    modport master (
        output keypad_row,
        input  keypad_col,
        input  key_position,
        input  key_valid,
        input  key_held
    );
`endif
endinterface

// File: rtl/mole_hit_encoder.sv
// 4x4 keypad scanner, frame debouncer and hole encoder (0..15 = hole, 16 = none).
// Optional MOLE_HIT_MASK_EN adds mole16bit/key_hit on the interface.
//
// state | meaning
// COL0  | column 0 driven low, rows sampled on last dwell cycle
// COL1  | column 1 driven low
// COL2  | column 2 driven low
// COL3  | column 3 driven low; last dwell cycle is frame end
module mole_hit_encoder #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input logic           clk,
    input logic           rst,
    mole_hit_encoder_if.slave kp
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_FRAMES - 1);
    localparam logic [4:0]    NO_KEY     = 5'd16;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } col_state_e;

    col_state_e    state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [4:0]    acc_q, acc_d;
    logic [4:0]    last_q, last_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [4:0]    pos_q, pos_d;
    logic          valid_q, valid_d;
    logic          held_q, held_d;

    logic [1:0]    col_idx;
    logic          dwell_last;
    logic [4:0]    cand;
    logic [4:0]    merged;

    assign col_idx    = state_q;
    assign dwell_last = (dwell_q == DWELL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= COL0;
            dwell_q  <= '0;
            acc_q    <= NO_KEY;
            last_q   <= NO_KEY;
            stable_q <= '0;
            pos_q    <= NO_KEY;
            valid_q  <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            acc_q    <= acc_d;
            last_q   <= last_d;
            stable_q <= stable_d;
            pos_q    <= pos_d;
            valid_q  <= valid_d;
            held_q   <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (dwell_last) begin
            case (state_q)
                COL0:    state_d = COL1;
                COL1:    state_d = COL2;
                COL2:    state_d = COL3;
                COL3:    state_d = COL0;
                default: state_d = COL0;
            endcase
        end
    end

    // Lowest pressed row in the driven column gives the lowest code for that column.
    always_comb begin
        cand = NO_KEY;
        for (int r = 3; r >= 0; r--) begin
            if (!kp.keypad_row[r]) begin
                cand = {1'b0, r[1:0], col_idx};
            end
        end
        merged = (cand < acc_q) ? cand : acc_q;
    end

    always_comb begin
        dwell_d  = dwell_q + 1'b1;
        acc_d    = acc_q;
        last_d   = last_q;
        stable_d = stable_q;
        pos_d    = pos_q;
        valid_d  = 1'b0;
        held_d   = held_q;

        if (dwell_last) begin
            dwell_d = '0;
            if (state_q != COL3) begin
                acc_d = merged;
            end else begin
                acc_d = NO_KEY;
                if (merged == last_q) begin
                    if (stable_q != STABLE_MAX) begin
                        stable_d = stable_q + 1'b1;
                    end
                end else begin
                    last_d   = merged;
                    stable_d = '0;
                end
                // Release never strobes; any change to a real hole does.
                if ((stable_d == STABLE_MAX) && (last_d != pos_q)) begin
                    pos_d   = last_d;
                    held_d  = (last_d != NO_KEY);
                    valid_d = (last_d != NO_KEY);
                end
            end
        end
    end

    assign kp.keypad_col   = ~(4'b0001 << col_idx);
    assign kp.key_position = pos_q;
    assign kp.key_valid    = valid_q;
    assign kp.key_held     = held_q;

`ifdef MOLE_HIT_MASK_EN
    // Mask is looked at during the strobe cycle itself, so no extra register.
    assign kp.key_hit = valid_q & kp.mole16bit[pos_q[3:0]];
`endif

endmodule

// File: tb/tb_mole_hit_encoder.sv
// Self-checking bench for mole_hit_encoder: directed tables, hand sequences and random frames
// against a frame-level reference model. Build with MOLE_HIT_MASK_EN to also exercise key_hit.
module tb_mole_hit_encoder;

    localparam int SD    = 4;
    localparam int DB    = 3;
    localparam int FRAME = 4 * SD;

    typedef struct {
        logic [15:0] keys;
        int          frames;
        int          exp_pos;
        int          exp_strobes;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = '0;
    logic [3:0]  row_drv;

    always #5 clk = ~clk;

    mole_hit_encoder_if kp();

    mole_hit_encoder #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DB)) dut (
        .clk(clk),
        .rst(rst),
        .kp (kp)
    );

    // Physical keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_drv = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kp.keypad_col[c]) row_drv[r] = 1'b0;
    end
    assign kp.keypad_row = row_drv;

`ifdef MOLE_HIT_MASK_EN
    logic [15:0] mole = '0;
    assign kp.mole16bit = mole;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hist[$];
    int exp_pos = 16;
    bit exp_valid = 1'b0;
    int seg_strobes = 0;

    function automatic int lowest(input logic [15:0] k);
        for (int i = 0; i < 16; i++) if (k[i]) return i;
        return 16;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the reference model across the edge, then compare every output.
    task automatic tick();
        int         fc;
        bit         same;
        logic [3:0] one;
        logic [3:0] exp_col;
        @(posedge clk);
        if (rst) begin
            cyc = 0;
            hist.delete();
            exp_pos   = 16;
            exp_valid = 1'b0;
        end else begin
            exp_valid = 1'b0;
            if (cyc % FRAME == FRAME - 1) begin
                fc = lowest(keys);
                hist.push_back(fc);
                if (hist.size() > DB) void'(hist.pop_front());
                if (hist.size() == DB) begin
                    same = 1'b1;
                    foreach (hist[i]) if (hist[i] != fc) same = 1'b0;
                    if (same && fc != exp_pos) begin
                        exp_pos   = fc;
                        exp_valid = (fc != 16);
                    end
                end
            end
            cyc++;
        end
        #1;
        one     = 4'b0001;
        exp_col = ~(one << ((cyc / SD) % 4));
        if (kp.key_valid) seg_strobes++;
        check("keypad_col", int'(kp.keypad_col), int'(exp_col));
        check("key_position", int'(kp.key_position), exp_pos);
        check("key_valid", int'(kp.key_valid), int'(exp_valid));
        check("key_held", int'(kp.key_held), int'(exp_pos != 16));
`ifdef MOLE_HIT_MASK_EN
        check("key_hit", int'(kp.key_hit), int'(exp_valid && exp_pos < 16 && mole[exp_pos[3:0]]));
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n * FRAME; i++) tick();
    endtask

    vec_t vecs[12];
    int   first_strobe;

    initial begin
        vecs[0]  = '{16'h2004, 4, 2,  1};   // holes 13 and 2 together
        vecs[1]  = '{16'h2000, 4, 13, 1};   // release 2, 13 still held
        vecs[2]  = '{16'h0000, 4, 16, 0};
        vecs[3]  = '{16'h0022, 4, 1,  1};   // same column, rows 0 and 1
        vecs[4]  = '{16'h9000, 4, 12, 1};   // same row, cols 0 and 3
        vecs[5]  = '{16'h0000, 4, 16, 0};
        vecs[6]  = '{16'h0008, 2, 16, 0};   // one frame short of debounce
        vecs[7]  = '{16'h0000, 3, 16, 0};
        vecs[8]  = '{16'h0080, 3, 7,  1};   // exactly the debounce length
        vecs[9]  = '{16'h0080, 5, 7,  0};
        vecs[10] = '{16'h8001, 3, 0,  1};   // direct change 7 -> 0
        vecs[11] = '{16'h0000, 3, 16, 0};

        // Idle scan after reset
        keys = '0;
        do_reset();
        seg_strobes = 0;
        for (int i = 0; i < 200; i++) tick();
        check("idle_strobes", seg_strobes, 0);
        check("idle_position", int'(kp.key_position), 16);

        // Hole 6 held from reset release
`ifdef MOLE_HIT_MASK_EN
        mole = 16'h0040;
`endif
        keys = 16'h0040;
        do_reset();
        seg_strobes  = 0;
        first_strobe = -1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (kp.key_valid && first_strobe < 0) first_strobe = i;
        end
        check("press6_strobe_seen", int'(first_strobe > 0 && first_strobe <= 50), 1);
        check("press6_strobes", seg_strobes, 1);
        check("press6_position", int'(kp.key_position), 6);
        seg_strobes = 0;
        for (int i = 0; i < 510; i++) tick();
        check("hold6_no_restrobe", seg_strobes, 0);

        // Release; 50 + 510 ticks above leaves us frame-aligned
        keys = '0;
        seg_strobes = 0;
        for (int i = 0; i < 50; i++) tick();
        check("release_position", int'(kp.key_position), 16);
        check("release_held", int'(kp.key_held), 0);
        check("release_strobes", seg_strobes, 0);
        for (int i = 0; i < 14; i++) tick();

        // Bounce on hole 9, then settle
        seg_strobes = 0;
        for (int f = 0; f < 10; f++) begin
            keys = (f % 2 == 0) ? 16'h0200 : 16'h0000;
            run_frames(1);
        end
        check("bounce_strobes", seg_strobes, 0);
        check("bounce_position", int'(kp.key_position), 16);
        keys = 16'h0200;
        seg_strobes = 0;
        run_frames(4);
        check("settle9_strobes", seg_strobes, 1);
        check("settle9_position", int'(kp.key_position), 9);

        // Directed table
        for (int v = 0; v < 12; v++) begin
            keys = vecs[v].keys;
            seg_strobes = 0;
            run_frames(vecs[v].frames);
            check($sformatf("vec%0d_position", v), int'(kp.key_position), vecs[v].exp_pos);
            check($sformatf("vec%0d_strobes", v), seg_strobes, vecs[v].exp_strobes);
        end

        // Random frames, reference model checks every cycle
        for (int f = 0; f < 80; f++) begin
            if ($urandom_range(0, 9) >= 6) begin
                case ($urandom_range(0, 2))
                    0:       keys = '0;
                    1:       keys = 16'(1) << $urandom_range(0, 15);
                    default: keys = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
                endcase
            end
`ifdef MOLE_HIT_MASK_EN
            mole = 16'(1) << $urandom_range(0, 15);
`endif
            run_frames(1);
        end

`ifdef MOLE_HIT_MASK_EN
        // Mask miss: valid strobes but no hit
        keys = '0;
        run_frames(4);
        mole = 16'h0001;
        keys = 16'h0040;
        seg_strobes = 0;
        run_frames(4);
        check("mask_miss_strobes", seg_strobes, 1);
`endif

        // Reset in the middle of a held press
        keys = 16'h0040;
        run_frames(4);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        check("midrst_col", int'(kp.keypad_col), 4'he);
        check("midrst_position", int'(kp.key_position), 16);
        check("midrst_valid", int'(kp.key_valid), 0);
        check("midrst_held", int'(kp.key_held), 0);
`ifdef MOLE_HIT_MASK_EN
        check("midrst_hit", int'(kp.key_hit), 0);
`endif
        rst = 1'b0;
        run_frames(4);
        check("post_rst_position", int'(kp.key_position), 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
